// File: rtl/proc_flex_pkg.sv
// Shared encodings for the proc_flex core: opcodes, branch conditions,
// bus-source selects, FSM states and the branch condition evaluator.
package proc_flex_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVTB = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    localparam logic [2:0] C_AL = 3'b000;
    localparam logic [2:0] C_EQ = 3'b001;
    localparam logic [2:0] C_NE = 3'b010;
    localparam logic [2:0] C_CC = 3'b011;
    localparam logic [2:0] C_CS = 3'b100;
    localparam logic [2:0] C_PL = 3'b101;
    localparam logic [2:0] C_MI = 3'b110;
    localparam logic [2:0] C_NV = 3'b111;

    // R0..R6 and PC share the register-number encoding so rX/rY map directly.
    typedef enum logic [3:0] {
        SEL_R0, SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5, SEL_R6, SEL_PC,
        SEL_G, SEL_D9, SEL_D8, SEL_DIN
    } sel_t;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;

    // flags are {N,Z,C}
    function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
        case (cond)
            C_AL:    return 1'b1;
            C_EQ:    return flags[1];
            C_NE:    return !flags[1];
            C_CC:    return !flags[0];
            C_CS:    return flags[0];
            C_PL:    return !flags[2];
            C_MI:    return flags[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/proc_flex_if.sv
// Memory/IO bus of the proc_flex core.
// No valid/ready pairing: Run gates the fetch in T0, Done is high in the last
// cycle of each instruction, W is a single-cycle write strobe qualifying ADDR/DOUT,
// and DIN is expected MEM_LAT cycles after ADDR is loaded.
interface proc_flex_if #(parameter int DW = 16);
    logic          Run;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT;
    logic [DW-1:0] ADDR;
    logic          W;
    logic          Done;
    logic [2:0]    Flags;

    modport master (input Run, DIN, output DOUT, ADDR, W, Done, Flags);
    modport slave  (output Run, DIN, input DOUT, ADDR, W, Done, Flags);
endinterface

// File: rtl/proc_flex_alu.sv
// Width-parametrised add/sub/and; subtraction is a + ~b + 1 so C=1 means no borrow.
module proc_flex_alu
    import proc_flex_pkg::*;
#(
    parameter int DW = 16
) (
    input  alu_op_t       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          n,
    output logic          z,
    output logic          c
);

    logic [DW:0] sum;

    always_comb begin
        sum = '0;
        case (op)
            ALU_ADD: sum = {1'b0, a} + {1'b0, b};
            ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
            ALU_AND: sum = {1'b0, a & b};
            default: sum = '0;
        endcase
    end

    assign result = sum[DW-1:0];
    assign c      = sum[DW];
    assign n      = sum[DW-1];
    assign z      = (sum[DW-1:0] == '0);

endmodule

// File: rtl/proc_flex.sv
// Multi-cycle accumulator-bus core: r0..r6 plus PC (r7), A/G staging registers,
// {N,Z,C} flags and conditional PC-relative branches.
module proc_flex
    import proc_flex_pkg::*;
#(
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic            Clock,
    input  logic            Resetn,
    proc_flex_if.master     bus,
    output state_t          dbg_state
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t        state;
    logic [DW-1:0] regs [0:7];
    logic [DW-1:0] a_reg;
    logic [DW-1:0] g_reg;
    logic [15:0]   ir;
    logic [1:0]    wait_cnt;
    logic [2:0]    flags;

    logic [2:0]    op;
    logic          m;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [DW-1:0] d9;
    logic [DW-1:0] d8;
    logic          is_alu;
    logic          is_branch;
    logic          take;
    logic          short_instr;
    sel_t          bus_sel;
    alu_op_t       alu_op;
    logic [DW-1:0] bus_val;
    logic [DW-1:0] alu_res;
    logic          alu_n;
    logic          alu_z;
    logic          alu_c;

    assign op        = ir[15:13];
    assign m         = ir[12];
    assign rx        = ir[11:9];
    assign ry        = ir[2:0];
    assign d9        = {{(DW-9){ir[8]}}, ir[8:0]};
    assign d8        = {ir[7:0], {(DW-8){1'b0}}};
    assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_CMP);
    assign is_branch = (op == OP_MVTB) && !m;
    assign take      = cond_true(rx, flags);
    // mv, mvt and untaken branches finish in T3
    assign short_instr = (state == T3) &&
                         ((op == OP_MV) || ((op == OP_MVTB) && (m || !take)));

    assign bus.Done  = short_instr || (state == T5);
    assign bus.Flags = flags;
    assign dbg_state = state;

    always_comb begin
        bus_sel = SEL_G;
        alu_op  = ALU_ADD;
        case (state)
            T3: begin
                if (op == OP_MV)
                    bus_sel = m ? SEL_D9 : sel_t'({1'b0, ry});
                else if (op == OP_MVTB)
                    bus_sel = m ? SEL_D8 : SEL_PC;
                else if ((op == OP_LD) || (op == OP_ST))
                    bus_sel = sel_t'({1'b0, ry});
                else
                    bus_sel = sel_t'({1'b0, rx});
            end
            T4: begin
                if (op == OP_ST)
                    bus_sel = sel_t'({1'b0, rx});
                else if (is_branch)
                    bus_sel = SEL_D9;
                else
                    bus_sel = m ? SEL_D9 : sel_t'({1'b0, ry});
            end
            T5:      bus_sel = (op == OP_LD) ? SEL_DIN : SEL_G;
            default: bus_sel = SEL_G;
        endcase
        case (op)
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_AND:         alu_op = ALU_AND;
            default:        alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        bus_val = g_reg;
        case (bus_sel)
            SEL_G:   bus_val = g_reg;
            SEL_D9:  bus_val = d9;
            SEL_D8:  bus_val = d8;
            SEL_DIN: bus_val = bus.DIN;
            default: bus_val = regs[bus_sel[2:0]];
        endcase
    end

    proc_flex_alu #(.DW(DW)) u_alu (
        .op     (alu_op),
        .a      (a_reg),
        .b      (bus_val),
        .result (alu_res),
        .n      (alu_n),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= T0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            ir       <= '0;
            bus.ADDR <= '0;
            bus.DOUT <= '0;
            bus.W    <= 1'b0;
            flags    <= 3'b000;
            wait_cnt <= '0;
        end else begin
            bus.W <= 1'b0;
            case (state)
                T0: begin
                    bus.ADDR <= regs[7];
                    if (bus.Run) begin
                        regs[7] <= regs[7] + DW'(1);
                        state   <= T1;
                    end
                end
                T1: begin
                    if (wait_cnt == LAT_LAST) begin
                        wait_cnt <= '0;
                        state    <= T2;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                T2: begin
                    ir    <= bus.DIN[15:0];
                    state <= T3;
                end
                T3: begin
                    if ((op == OP_MV) || ((op == OP_MVTB) && m)) begin
                        regs[rx] <= bus_val;
                        state    <= T0;
                    end else if (is_branch && !take) begin
                        state <= T0;
                    end else if ((op == OP_LD) || (op == OP_ST)) begin
                        bus.ADDR <= bus_val;
                        state    <= T4;
                    end else begin
                        a_reg <= bus_val;
                        state <= T4;
                    end
                end
                T4: begin
                    if (op == OP_LD) begin
                        if (wait_cnt == LAT_LAST) begin
                            wait_cnt <= '0;
                            state    <= T5;
                        end else begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                    end else if (op == OP_ST) begin
                        bus.DOUT <= bus_val;
                        bus.W    <= 1'b1;
                        state    <= T5;
                    end else begin
                        g_reg <= alu_res;
                        // branch target arithmetic must leave the flags alone
                        if (!is_branch)
                            flags <= {alu_n, alu_z, (op == OP_AND) ? flags[0] : alu_c};
                        state <= T5;
                    end
                end
                T5: begin
                    if ((op == OP_LD) || (is_alu && (op != OP_CMP)) || is_branch)
                        regs[is_branch ? 3'd7 : rx] <= bus_val;
                    state <= T0;
                end
                default: state <= T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_flex.sv
// Directed bench: a DW=16/MEM_LAT=1 core and a DW=32/MEM_LAT=3 core, each fed
// by a small latency-matched ROM model, checked against hand-computed values.
module tb_proc_flex;
    import proc_flex_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn_a;
    logic resetn_b;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and memory models ----------------
    proc_flex_if #(.DW(16)) bus_a ();
    proc_flex_if #(.DW(32)) bus_b ();
    state_t state_a;
    state_t state_b;

    proc_flex #(.DW(16), .MEM_LAT(1)) dut_a (
        .Clock(clk), .Resetn(resetn_a), .bus(bus_a), .dbg_state(state_a)
    );
    proc_flex #(.DW(32), .MEM_LAT(3)) dut_b (
        .Clock(clk), .Resetn(resetn_b), .bus(bus_b), .dbg_state(state_b)
    );

    logic [15:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [15:0] pipe_a;
    logic [31:0] pipe_b [0:2];

    always @(posedge clk) begin
        pipe_a    <= mem_a[bus_a.ADDR[7:0]];
        pipe_b[0] <= mem_b[bus_b.ADDR[7:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.DIN = pipe_a;
    assign bus_b.DIN = pipe_b[2];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    int done_cnt_a = 0, done_cnt_b = 0;
    int last_done_a = 0, last_done_b = 0;
    int len_a = 0, len_b = 0;
    int w_cnt_a = 0;
    int t1_b = 0, t4_b = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (bus_a.W) begin
            w_cnt_a++;
            if (exp_q.size() == 0) begin
                check("st_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("st_addr", {16'h0, bus_a.ADDR}, {16'h0, e[31:16]});
                check("st_dout", {16'h0, bus_a.DOUT}, {16'h0, e[15:0]});
            end
        end
        if (bus_a.Done) begin
            done_cnt_a++;
            len_a = cyc - last_done_a;
            last_done_a = cyc;
        end
        if (bus_b.Done) begin
            done_cnt_b++;
            len_b = cyc - last_done_b;
            last_done_b = cyc;
        end
        if (state_b == T1) t1_b++;
        if (state_b == T4) t4_b++;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                        input logic [2:0] x, input logic [8:0] d);
        return {op, m, x, d};
    endfunction

    // Returns #1 after the edge that commits the n-th Done from now.
    task automatic wait_done(input int which, input int n, input int budget);
        int target;
        int k;
        target = ((which == 0) ? done_cnt_a : done_cnt_b) + n;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            if (((which == 0) ? done_cnt_a : done_cnt_b) >= target) break;
        end
        #1;
        check("done_in_budget", {31'd0, k < budget}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        resetn_a  = 1'b0;
        resetn_b  = 1'b0;
        bus_a.Run = 1'b0;
        bus_b.Run = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[0] = enc(OP_ADD - 3'd2, 1'b1, 3'd0, 9'h1FF);   // mv  r0,#-1
        mem_a[1] = enc(OP_ADD, 1'b1, 3'd0, 9'd1);            // add r0,#1
        mem_a[2] = enc(OP_MV, 1'b1, 3'd1, 9'd5);             // mv  r1,#5
        mem_a[3] = enc(OP_CMP, 1'b1, 3'd1, 9'd7);            // cmp r1,#7
        mem_a[4] = enc(OP_MVTB, 1'b0, C_MI, 9'h1FD);         // bmi #-3
        mem_b[0] = {16'h0, enc(OP_MV, 1'b1, 3'd6, 9'h080)};  // mv  r6,#0x80
        mem_b[1] = {16'h0, enc(OP_LD, 1'b0, 3'd5, 9'd6)};    // ld  r5,[r6]
        mem_b[2] = {16'h0, enc(OP_MV, 1'b1, 3'd0, 9'h1FE)};  // mv  r0,#-2
        mem_b[8'h80] = 32'hCAFE1234;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {29'd0, state_a}, {29'd0, T0});
        check("rst_addr", {16'h0, bus_a.ADDR}, 32'h0);
        check("rst_w", {31'd0, bus_a.W}, 32'd0);
        check("rst_flags", {29'd0, bus_a.Flags}, 32'd0);
        for (int i = 0; i < 8; i++) check("rst_reg", {16'h0, dut_a.regs[i]}, 32'h0);

        // Run low must hold T0 without advancing the PC
        resetn_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_state", {29'd0, state_a}, {29'd0, T0});
        check("stall_pc", {16'h0, dut_a.regs[7]}, 32'h0);

        bus_a.Run = 1'b1;
        wait_done(0, 2, 40);
        check("add_r0", {16'h0, dut_a.regs[0]}, 32'h0000);
        check("add_flags", {29'd0, bus_a.Flags}, 32'b011);
        check("add_len", len_a, 32'd6);

        wait_done(0, 3, 60);
        bus_a.Run = 1'b0;
        check("cmp_r1", {16'h0, dut_a.regs[1]}, 32'h0005);
        check("cmp_flags", {29'd0, bus_a.Flags}, 32'b100);
        check("bmi_pc", {16'h0, dut_a.regs[7]}, 32'd2);

        // second program: flag setup, mvt, untaken bne, store, interrupted load
        mem_a[0] = enc(OP_MV, 1'b1, 3'd0, 9'd0);             // mv  r0,#0
        mem_a[1] = enc(OP_CMP, 1'b1, 3'd0, 9'd0);            // cmp r0,#0
        mem_a[2] = enc(OP_MVTB, 1'b1, 3'd2, 9'h012);         // mvt r2,#0x12
        mem_a[3] = enc(OP_MVTB, 1'b0, C_NE, 9'd4);           // bne #4
        mem_a[4] = enc(OP_MVTB, 1'b1, 3'd3, 9'h0BE);         // mvt r3,#0xBE
        mem_a[5] = enc(OP_ADD, 1'b1, 3'd3, 9'h0EF);          // add r3,#0xEF
        mem_a[6] = enc(OP_MVTB, 1'b1, 3'd4, 9'h010);         // mvt r4,#0x10
        mem_a[7] = enc(OP_ST, 1'b0, 3'd3, 9'd4);             // st  r3,[r4]
        mem_a[8] = enc(OP_LD, 1'b0, 3'd5, 9'd4);             // ld  r5,[r4]
        resetn_a = 1'b0;
        @(posedge clk);
        #1;
        resetn_a = 1'b1;
        exp_q.push_back({16'h1000, 16'hBEEF});
        bus_a.Run = 1'b1;

        wait_done(0, 4, 60);
        check("mvt_r2", {16'h0, dut_a.regs[2]}, 32'h1200);
        check("bne_pc", {16'h0, dut_a.regs[7]}, 32'd4);
        check("bne_len", len_a, 32'd4);
        check("bne_flags", {29'd0, bus_a.Flags}, 32'b011);

        wait_done(0, 4, 60);
        check("st_r3", {16'h0, dut_a.regs[3]}, 32'hBEEF);
        check("st_r4", {16'h0, dut_a.regs[4]}, 32'h1000);
        check("st_flags", {29'd0, bus_a.Flags}, 32'b100);
        check("st_w_cycles", w_cnt_a, 32'd1);
        check("st_q_empty", exp_q.size(), 32'd0);

        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (state_a == T4) break;
        end
        check("ld_reached_t4", {31'd0, k < 20}, 32'd1);
        resetn_a  = 1'b0;
        bus_a.Run = 1'b0;
        @(posedge clk);
        #1;
        check("midld_state", {29'd0, state_a}, {29'd0, T0});
        check("midld_addr", {16'h0, bus_a.ADDR}, 32'h0);
        check("midld_w", {31'd0, bus_a.W}, 32'd0);
        check("midld_flags", {29'd0, bus_a.Flags}, 32'd0);
        for (int i = 0; i < 8; i++) check("midld_reg", {16'h0, dut_a.regs[i]}, 32'h0);
        resetn_a  = 1'b1;
        bus_a.Run = 1'b1;
        @(posedge clk);
        #1;
        bus_a.Run = 1'b0;
        check("refetch_addr", {16'h0, bus_a.ADDR}, 32'h0);
        check("refetch_pc", {16'h0, dut_a.regs[7]}, 32'd1);
        check("refetch_state", {29'd0, state_a}, {29'd0, T1});

        // wide core with three-cycle memory
        resetn_b  = 1'b1;
        bus_b.Run = 1'b1;
        wait_done(1, 2, 80);
        check("ld_len", len_b, 32'd10);
        check("ld_r6", dut_b.regs[6], 32'h80);
        check("ld_r5", dut_b.regs[5], 32'hCAFE1234);
        check("ld_t4_cycles", t4_b, 32'd3);
        wait_done(1, 1, 40);
        bus_b.Run = 1'b0;
        check("mv32_r0", dut_b.regs[0], 32'hFFFFFFFE);
        check("mv32_len", len_b, 32'd6);
        check("t1_cycles", t1_b, 32'd9);
        check("b_flags", {29'd0, bus_b.Flags}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/proc_flex.md
Name: proc_flex

Overview:
- Next-generation multi-cycle accumulator-bus processor core for the lab SoC. Drop-in successor to the existing 16-bit core.
- Adds a parametrised datapath width and a parametrised synchronous-memory latency.
- Adds condition flags, a compare instruction and conditional PC-relative branches.
- Talks to a synchronous RAM/IO fabric over ADDR/DOUT/DIN/W; r7 is the PC.

Parameters:
- DW, 16, datapath/register/bus width; legal range 16..32.
- MEM_LAT, 1, wait cycles between ADDR load and valid DIN; legal range 1..4.

Ports:
- Clock  in  1  system clock, all state on rising edge
- Resetn  in  1  synchronous, active-low reset
- Run  in  1  high allows a fetch in T0; low stalls in T0
- DIN  in  DW  read data from memory; instruction is DIN[15:0]
- DOUT  out  DW  registered write data
- ADDR  out  DW  registered memory address
- W  out  1  registered write strobe
- Done  out  1  combinational, high in the last cycle of each instruction
- Flags  out  3  {N,Z,C} condition flags

Behaviour:
- Reset (Resetn=0 at an edge) forces the following, including mid-instruction:
  - FSM to T0.
  - r0..r6, PC, A, G, IR, ADDR, DOUT = 0; W=0; Flags=000; wait counter=0.
- Instruction format: III M XXX DDDDDDDDD.
  - D9 = IR[8:0] sign-extended to DW.
  - rY = IR[2:0].
  - Cond = XXX for branches.
- Opcodes:
  - 000 mv rX,rY|#D
  - 001 M=1 mvt: rX <- {IR[7:0], (DW-8) zeros}
  - 001 M=0 b{cond} #D
  - 010 add
  - 011 sub
  - 100 ld rX,[rY]
  - 101 st rX,[rY]
  - 110 and
  - 111 cmp rX,rY|#D
- FSM states and actions:
  - T0: ADDR<=PC; PC++ when Run. Run=0 holds T0, else next state is T1.
  - T1: memory wait. Stays MEM_LAT cycles, counted by the wait counter.
  - T2: IR<=DIN[15:0].
  - T3/T4/T5: execute.
- mv, mvt: T3 writes rX; Done.
- add, sub, and, cmp:
  - T3: A<=rX.
  - T4: G<=ALU(A, rY|D9); flags updated.
  - T5: rX<=G and Done. cmp: no register write, Done.
- ALU:
  - Arithmetic is modulo 2^DW.
  - add: C = carry-out.
  - sub/cmp: computed as A+~B+1; C = carry-out, so 1 means no borrow.
  - and: C unchanged.
  - Z = (result==0); N = result[DW-1].
- ld:
  - T3: ADDR<=rY.
  - T4: wait state, held MEM_LAT cycles.
  - T5: rX<=DIN; Done.
- st:
  - T3: ADDR<=rY.
  - T4: DOUT<=rX, W<=1 (visible the following cycle, exactly one cycle wide).
  - T5: Done.
- b{cond} condition codes:
  - 000 always
  - 001 eq (Z)
  - 010 ne (!Z)
  - 011 cc (!C)
  - 100 cs (C)
  - 101 pl (!N)
  - 110 mi (N)
  - 111 never
- b{cond} sequencing:
  - Condition false: Done in T3.
  - Condition true: T3 A<=PC (already incremented); T4 G<=A+D9, flags not updated; T5 PC<=G, Done.
- Writes to PC:
  - Any rX=7 write loads the PC.
  - A PC load never coincides with a PC increment (increment only in T0).
- Done: the next state after Done is T0.
- Flags change only in T4 of add/sub/and/cmp. Flags are not altered by mv/ld/st/b.

Decomposition:
- Package proc_flex_pkg holds:
  - opcode constants
  - cond codes
  - bus-select encodings (R0..R6, PC, G, D9, D8, DIN)
  - FSM state encoding
- One natural sub-module: proc_flex_alu (DW-parametrised add/sub/and, producing result plus N/Z/C).
- Existing register and PC-counter leaf modules are reused with the width parameter.

Test Plan:
- Reset mid-ld (assert Resetn=0 in T4) -> next cycle all regs 0, W=0, Flags=000; fetch resumes at ADDR=0 once Run=1.
- mv r0,#-1; add r0,#1 (DW=16) -> r0=0x0000, Flags {N,Z,C}={0,1,1}; instruction takes 6 cycles incl. fetch with MEM_LAT=1.
- mv r1,#5; cmp r1,#7; bmi #-3 -> Flags N=1,C=0; r1 stays 5; PC = branch_addr+1-3.
- mvt r2,#0x12 then bne #4 with Z=1 -> r2=0x1200; branch not taken; Done in T3; PC = branch_addr+1.
- st r3,[r4] with r3=0xBEEF, r4=0x1000 -> ADDR=0x1000, DOUT=0xBEEF, W high exactly one cycle; Flags unchanged.
- DW=32, MEM_LAT=3: ld r5,[r6] -> T1 and T4 each last 3 cycles; r5 = DIN captured in T5; mv r0,#-2 -> r0=0xFFFFFFFE.
